// File: rtl/sysc_brk_trap_ctrl.sv
// SYSCALL/BREAK trap sequencer: accept, drain older instructions, write exception CSRs,
// then redirect fetch to EENTRY with a pipeline flush.
module sysc_brk_trap_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter logic [5:0]  ECODE_SYS     = 6'h0B,
    parameter logic [5:0]  ECODE_BRK     = 6'h0C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [14:0] id_code,
    input  logic [1:0]  sysc_brk_op_type,
    input  logic        pipe_empty,
    input  logic        ext_flush,
    input  logic [31:0] csr_eentry,
    output logic        id_stall,
    output logic        csr_we,
    output logic [31:0] csr_era,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic [14:0] trap_code,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        drain_timeout
);

    localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    localparam logic [1:0] SB_SYSCALL    = 2'b00;
    localparam logic [1:0] SB_BREAK      = 2'b01;
    localparam logic [1:0] INVALID_OP_2B = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      cap_pc;
    logic [14:0]      cap_code;
    logic [5:0]       cap_ecode;
    logic [5:0]       op_ecode;

    // Ecode selected from the op type at accept time
    always_comb begin
        op_ecode = ECODE_BRK;
        case (sysc_brk_op_type)
            SB_SYSCALL: op_ecode = ECODE_SYS;
            SB_BREAK:   op_ecode = ECODE_BRK;
            default:    op_ecode = ECODE_BRK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ext_flush wins over pipe_empty, which wins over the drain timeout
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (id_valid && (sysc_brk_op_type != INVALID_OP_2B) && !ext_flush) begin
                    accept     = 1'b1;
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (ext_flush) begin
                    next_state = IDLE;
                end else if (pipe_empty) begin
                    next_state = COMMIT;
                end else if (cnt == CNT_LAST) begin
                    next_state  = COMMIT;
                    timeout_hit = 1'b1;
                end
            end
            COMMIT:   next_state = REDIRECT;
            REDIRECT: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Outputs are loaded from next_state so they line up with the registered state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_stall       <= 1'b0;
            csr_we         <= 1'b0;
            csr_era        <= '0;
            csr_ecode      <= '0;
            trap_code      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            drain_timeout  <= 1'b0;
            cnt            <= '0;
            cap_pc         <= '0;
            cap_code       <= '0;
            cap_ecode      <= '0;
        end else begin
            id_stall       <= (next_state != IDLE);
            csr_we         <= (next_state == COMMIT);
            redirect_valid <= (next_state == REDIRECT);
            flush          <= (next_state == REDIRECT);

            if (accept) begin
                cap_pc    <= id_pc;
                cap_code  <= id_code;
                cap_ecode <= op_ecode;
                cnt       <= '0;
            end else if ((state == DRAIN) && ext_flush) begin
                cap_pc    <= '0;
                cap_code  <= '0;
                cap_ecode <= '0;
                cnt       <= '0;
            end else if ((state == DRAIN) && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (timeout_hit) begin
                drain_timeout <= 1'b1;
            end

            if (next_state == COMMIT) begin
                csr_era   <= cap_pc;
                csr_ecode <= cap_ecode;
                trap_code <= cap_code;
            end

            if (next_state == REDIRECT) begin
                redirect_pc <= csr_eentry;
            end
        end
    end

    assign csr_esubcode = '0;

endmodule

// File: tb/tb_sysc_brk_trap_ctrl.sv
// Directed bench for sysc_brk_trap_ctrl: inputs change 1 ns after posedge, outputs checked there.
module tb_sysc_brk_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [14:0] id_code;
    logic [1:0]  sysc_brk_op_type;
    logic        pipe_empty;
    logic        ext_flush;
    logic [31:0] csr_eentry;
    logic        id_stall;
    logic        csr_we;
    logic [31:0] csr_era;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [14:0] trap_code;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        drain_timeout;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_SYS = 2'b00;
    localparam logic [1:0] OP_BRK = 2'b01;
    localparam logic [1:0] OP_INV = 2'b11;

    sysc_brk_trap_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_code          (id_code),
        .sysc_brk_op_type (sysc_brk_op_type),
        .pipe_empty       (pipe_empty),
        .ext_flush        (ext_flush),
        .csr_eentry       (csr_eentry),
        .id_stall         (id_stall),
        .csr_we           (csr_we),
        .csr_era          (csr_era),
        .csr_ecode        (csr_ecode),
        .csr_esubcode     (csr_esubcode),
        .trap_code        (trap_code),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .drain_timeout    (drain_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [1:0] op, input logic [31:0] pc, input logic [14:0] code);
        id_valid         = 1'b1;
        sysc_brk_op_type = op;
        id_pc            = pc;
        id_code          = code;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_pc = '0; id_code = '0;
        sysc_brk_op_type = OP_INV; pipe_empty = 1'b0; ext_flush = 1'b0;
        csr_eentry = 32'h1C00_8000;

        // reset, two cycles
        tick(); tick();
        check("rst_stall", 32'(id_stall), 0);
        check("rst_we", 32'(csr_we), 0);
        check("rst_era", csr_era, 0);
        check("rst_ecode", 32'(csr_ecode), 0);
        check("rst_esub", 32'(csr_esubcode), 0);
        check("rst_code", 32'(trap_code), 0);
        check("rst_redir", 32'(redirect_valid), 0);
        check("rst_rpc", redirect_pc, 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_dto", 32'(drain_timeout), 0);
        rst_n = 1'b1;

        // SYSCALL with pipeline already empty
        pipe_empty = 1'b1;
        present(OP_SYS, 32'h1C00_0100, 15'h0011);
        tick();
        check("sys_t1_stall", 32'(id_stall), 1);
        check("sys_t1_we", 32'(csr_we), 0);
        id_valid = 1'b0;
        tick();
        check("sys_t2_we", 32'(csr_we), 1);
        check("sys_t2_era", csr_era, 32'h1C00_0100);
        check("sys_t2_ecode", 32'(csr_ecode), 32'h0B);
        check("sys_t2_code", 32'(trap_code), 32'h0011);
        check("sys_t2_esub", 32'(csr_esubcode), 0);
        check("sys_t2_redir", 32'(redirect_valid), 0);
        check("sys_t2_stall", 32'(id_stall), 1);
        tick();
        check("sys_t3_we", 32'(csr_we), 0);
        check("sys_t3_redir", 32'(redirect_valid), 1);
        check("sys_t3_flush", 32'(flush), 1);
        check("sys_t3_rpc", redirect_pc, 32'h1C00_8000);
        check("sys_t3_stall", 32'(id_stall), 1);
        tick();
        check("sys_t4_stall", 32'(id_stall), 0);
        check("sys_t4_redir", 32'(redirect_valid), 0);
        check("sys_t4_flush", 32'(flush), 0);

        // BREAK with pipe_empty low for five cycles after accept
        pipe_empty = 1'b0;
        present(OP_BRK, 32'h1C00_0200, 15'h0022);
        tick();
        id_valid = 1'b0;
        check("brk_t1_we", 32'(csr_we), 0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("brk_drain_we", 32'(csr_we), 0);
        end
        tick();
        pipe_empty = 1'b1;
        check("brk_t6_we", 32'(csr_we), 0);
        tick();
        check("brk_t7_we", 32'(csr_we), 1);
        check("brk_t7_ecode", 32'(csr_ecode), 32'h0C);
        check("brk_t7_era", csr_era, 32'h1C00_0200);
        check("brk_t7_code", 32'(trap_code), 32'h0022);
        tick();
        check("brk_t8_redir", 32'(redirect_valid), 1);
        check("brk_t8_dto", 32'(drain_timeout), 0);
        tick();
        check("brk_t9_stall", 32'(id_stall), 0);

        // ext_flush during DRAIN abandons the trap
        pipe_empty = 1'b0;
        present(OP_SYS, 32'h1C00_0a00, 15'h0033);
        tick();
        id_valid = 1'b0;
        tick();
        ext_flush = 1'b1;
        tick();
        ext_flush  = 1'b0;
        pipe_empty = 1'b1;
        check("xf_t3_stall", 32'(id_stall), 0);
        check("xf_t3_we", 32'(csr_we), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("xf_after_we", 32'(csr_we), 0);
            check("xf_after_redir", 32'(redirect_valid), 0);
        end

        // ext_flush with a valid trap in IDLE blocks the accept
        ext_flush = 1'b1;
        present(OP_SYS, 32'h1C00_0b00, 15'h0044);
        tick();
        check("xf_idle_stall", 32'(id_stall), 0);
        ext_flush = 1'b0;
        id_valid  = 1'b0;
        tick(); tick();
        check("xf_idle_we", 32'(csr_we), 0);

        // reset in DRAIN aborts without CSR write
        pipe_empty = 1'b0;
        present(OP_SYS, 32'h1C00_0c00, 15'h0055);
        tick();
        id_valid = 1'b0;
        check("rd_t1_stall", 32'(id_stall), 1);
        rst_n = 1'b0;
        tick();
        check("rd_stall", 32'(id_stall), 0);
        rst_n      = 1'b1;
        pipe_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd_we", 32'(csr_we), 0);
            check("rd_redir", 32'(redirect_valid), 0);
        end

        // drain timeout: 64 DRAIN cycles then forced commit
        pipe_empty = 1'b0;
        present(OP_SYS, 32'h1C00_0d00, 15'h0066);
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 1) id_valid = 1'b0;
            check("to_drain_we", 32'(csr_we), 0);
        end
        check("to_t64_dto", 32'(drain_timeout), 0);
        tick();
        check("to_t65_we", 32'(csr_we), 1);
        check("to_t65_dto", 32'(drain_timeout), 1);
        check("to_t65_era", csr_era, 32'h1C00_0d00);
        tick();
        check("to_t66_redir", 32'(redirect_valid), 1);
        tick();
        check("to_t67_stall", 32'(id_stall), 0);
        check("to_t67_dto", 32'(drain_timeout), 1);

        // a following SYSCALL still completes; flag stays set
        pipe_empty = 1'b1;
        csr_eentry = 32'h1C00_9000;
        present(OP_SYS, 32'h1C00_0300, 15'h0077);
        tick();
        id_valid = 1'b0;
        tick();
        check("post_we", 32'(csr_we), 1);
        check("post_era", csr_era, 32'h1C00_0300);
        tick();
        check("post_rpc", redirect_pc, 32'h1C00_9000);
        tick();
        check("post_dto", 32'(drain_timeout), 1);

        // back-to-back: BREAK, then SYSCALL held valid while stalled
        present(OP_BRK, 32'h1C00_0400, 15'h0044);
        tick();
        present(OP_SYS, 32'h1C00_0500, 15'h0055);
        check("b2b_t1_stall", 32'(id_stall), 1);
        tick();
        check("b2b_t2_we", 32'(csr_we), 1);
        check("b2b_t2_ecode", 32'(csr_ecode), 32'h0C);
        check("b2b_t2_era", csr_era, 32'h1C00_0400);
        tick();
        check("b2b_t3_we", 32'(csr_we), 0);
        check("b2b_t3_redir", 32'(redirect_valid), 1);
        tick();
        check("b2b_t4_stall", 32'(id_stall), 0);
        check("b2b_t4_we", 32'(csr_we), 0);
        tick();
        id_valid = 1'b0;
        check("b2b_t5_stall", 32'(id_stall), 1);
        check("b2b_t5_we", 32'(csr_we), 0);
        tick();
        check("b2b_t6_we", 32'(csr_we), 1);
        check("b2b_t6_ecode", 32'(csr_ecode), 32'h0B);
        check("b2b_t6_era", csr_era, 32'h1C00_0500);
        check("b2b_t6_code", 32'(trap_code), 32'h0055);
        tick();
        check("b2b_t7_we", 32'(csr_we), 0);
        check("b2b_t7_redir", 32'(redirect_valid), 1);
        tick();
        check("b2b_t8_stall", 32'(id_stall), 0);
        tick();
        check("b2b_t9_we", 32'(csr_we), 0);
        check("b2b_t9_stall", 32'(id_stall), 0);

        // invalid op never triggers; id_valid=0 ignores op type
        present(OP_INV, 32'h1C00_0600, 15'h0066);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("inv_stall", 32'(id_stall), 0);
            check("inv_we", 32'(csr_we), 0);
        end
        id_valid         = 1'b0;
        sysc_brk_op_type = OP_SYS;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("noval_stall", 32'(id_stall), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sysc_brk_trap_ctrl.md
Name: sysc_brk_trap_ctrl

Overview:
Execute-side trap sequencer that consumes the 2-bit `sysc_brk_op_type` from the SYSCALL/BREAK decoder. It accepts one trapping instruction and waits for older in-flight instructions to retire. It then writes the exception CSRs (ERA, ESTAT.Ecode/EsubCode) and issues a front-end redirect plus pipeline flush to EENTRY. Decode is stalled for the whole sequence.

Parameters:
- DRAIN_TIMEOUT, 64: maximum cycles spent in DRAIN before forced commit.
- ECODE_SYS, 6'h0B: Ecode written for SYSCALL.
- ECODE_BRK, 6'h0C: Ecode written for BREAK.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- id_valid  in  1  decode-stage instruction valid.
- id_pc  in  32  PC of decode-stage instruction.
- id_code  in  15  instr[14:0] code field of decode-stage instruction.
- sysc_brk_op_type  in  2  SB_SYSCALL / SB_BREAK / INVALID_OP_2B (defs.sv encodings).
- pipe_empty  in  1  high when all instructions older than the trap have retired.
- ext_flush  in  1  higher-priority flush (interrupt, older mispredict).
- csr_eentry  in  32  current EENTRY CSR value.
- id_stall  out  1  holds decode while sequencer busy.
- csr_we  out  1  one-cycle CSR write strobe.
- csr_era  out  32  ERA value (trapping PC).
- csr_ecode  out  6  ESTAT.Ecode value.
- csr_esubcode  out  9  ESTAT.EsubCode value, always 0.
- trap_code  out  15  captured code field, valid with csr_we.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  32  redirect target.
- flush  out  1  one-cycle pipeline flush, coincident with redirect_valid.
- drain_timeout  out  1  sticky error flag.

Behaviour:
- Reset: rst_n low at posedge drives state IDLE. All outputs 0, counter 0, capture registers 0. Reset mid-sequence aborts with no CSR write or redirect.
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT. All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- Accept condition: IDLE, id_valid=1, `sysc_brk_op_type` != INVALID_OP_2B, and ext_flush=0.
  - On accept, capture id_pc, id_code, and type.
  - Next state is DRAIN; counter is cleared.
  - The accept cycle is the cycle in which the trapping instruction is consumed.
- id_stall = (state != IDLE).
- DRAIN:
  - Counter increments each cycle and saturates.
  - pipe_empty=1 → COMMIT.
  - Counter reaching DRAIN_TIMEOUT-1 with pipe_empty=0 → set drain_timeout and go to COMMIT (forced progress).
  - ext_flush=1 → IDLE. No CSR write, no redirect, captured state discarded.
  - ext_flush has priority over pipe_empty in the same cycle.
- COMMIT (exactly 1 cycle):
  - csr_we=1.
  - csr_era = captured PC.
  - csr_ecode = ECODE_SYS for SB_SYSCALL, ECODE_BRK for SB_BREAK.
  - csr_esubcode = 0.
  - trap_code = captured code.
  - ext_flush is ignored. Next state is REDIRECT.
- REDIRECT (exactly 1 cycle):
  - redirect_valid=1, flush=1.
  - redirect_pc = csr_eentry sampled in this cycle.
  - ext_flush is ignored. Next state is IDLE.
- Output defaults: csr_we/redirect_valid/flush are 0 outside their states. csr_era/csr_ecode/trap_code/redirect_pc hold their last values.
- Latency: accept at T; earliest csr_we at T+2; earliest redirect at T+3. IDLE is reached at T+4, and a new accept is possible at T+4.
- Simultaneous events in IDLE: ext_flush=1 with a valid trap → no accept. id_valid=0 → op type is ignored.
- drain_timeout: sticky until reset. It does not block later traps.
- Counter width: clog2(DRAIN_TIMEOUT+1).

Test Plan:
1. Reset with rst_n=0 for 2 cycles.
   - Required: all outputs 0, id_stall=0.
   - Assert rst_n=0 in DRAIN: state returns to IDLE, and csr_we never pulses.
2. SYSCALL, id_pc=0x1C000100, id_code=0x0011, pipe_empty=1 throughout, csr_eentry=0x1C008000.
   - Required at T+2: csr_we=1, csr_era=0x1C000100, csr_ecode=0x0B, trap_code=0x0011.
   - Required at T+3: redirect_valid=flush=1, redirect_pc=0x1C008000.
   - id_stall is high T+1..T+3.
3. BREAK, id_pc=0x1C000200, pipe_empty low for 5 cycles after accept.
   - Required: csr_we at T+7 with csr_ecode=0x0C; redirect at T+8; drain_timeout=0.
4. ext_flush in DRAIN.
   - Accept SYSCALL, then assert ext_flush at T+2 while pipe_empty=0.
   - Required: back to IDLE at T+3 with no csr_we/redirect; id_stall drops.
   - ext_flush together with a valid trap in IDLE: no accept.
5. pipe_empty held 0 with DRAIN_TIMEOUT=64.
   - Required: forced COMMIT after 64 DRAIN cycles, with drain_timeout=1 and staying 1.
   - A following SYSCALL still completes normally.
6. Back-to-back: BREAK then SYSCALL presented while stalled, then held valid.
   - Required: the second trap is accepted at T+4 with no lost or duplicated csr_we.
   - INVALID_OP_2B with id_valid=1 never triggers.
